// File: rtl/codec_sequencer.sv
// codec_sequencer
// Drives one encoder and one decoder through a start/done handshake for each
// K-bit word: encode, apply the channel error mask to the codeword, decode,
// then compare the decoded word with the original and report the result.
// A bounded wait on each done signal turns a stuck codec into a reported
// timeout rather than a hang. Saturating counters track delivered and failed words.

module codec_sequencer #(
   parameter int K       = 40,
   parameter int N       = 64,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [K-1:0]     in_data,
   input  logic [N-1:0]     in_mask,
   output logic             enc_start,
   output logic [K-1:0]     enc_data,
   input  logic [N-1:0]     enc_code,
   input  logic             enc_done,
   output logic             dec_start,
   output logic [N-1:0]     dec_code,
   input  logic [K-1:0]     dec_data,
   input  logic             dec_done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [K-1:0]     out_data,
   output logic             out_match,
   output logic             out_timeout,
   output logic [CNT_W-1:0] word_cnt,
   output logic [CNT_W-1:0] fail_cnt
);

   localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      IDLE,
      ENC_START,
      ENC_WAIT,
      DEC_START,
      DEC_WAIT,
      RESULT
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [N-1:0]  mask_q;
   logic [TW-1:0] timer;

   logic accept;
   logic enc_capture;
   logic dec_capture;
   logic abort;
   logic timer_clear;
   logic timer_inc;
   logic result_take;

   // State register; reset wins over any state, including the wait states.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode plus the handshake outputs and datapath strobes for the current state.
   always_comb begin
      state_next  = state;
      in_ready    = 1'b0;
      enc_start   = 1'b0;
      dec_start   = 1'b0;
      out_valid   = 1'b0;
      accept      = 1'b0;
      enc_capture = 1'b0;
      dec_capture = 1'b0;
      abort       = 1'b0;
      timer_clear = 1'b0;
      timer_inc   = 1'b0;
      result_take = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept     = 1'b1;
               state_next = ENC_START;
            end
         end
         ENC_START: begin
            enc_start   = 1'b1;
            timer_clear = 1'b1;
            state_next  = ENC_WAIT;
         end
         ENC_WAIT: begin
            if (enc_done) begin
               enc_capture = 1'b1;
               state_next  = DEC_START;
            end else begin
               timer_inc = 1'b1;
               if (timer == TIMER_LAST) begin
                  abort      = 1'b1;
                  state_next = RESULT;
               end
            end
         end
         DEC_START: begin
            dec_start   = 1'b1;
            timer_clear = 1'b1;
            state_next  = DEC_WAIT;
         end
         DEC_WAIT: begin
            if (dec_done) begin
               dec_capture = 1'b1;
               state_next  = RESULT;
            end else begin
               timer_inc = 1'b1;
               if (timer == TIMER_LAST) begin
                  abort      = 1'b1;
                  state_next = RESULT;
               end
            end
         end
         RESULT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               result_take = 1'b1;
               state_next  = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Word, mask, codeword and result capture; the timer counts cycles spent in a wait state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         enc_data    <= '0;
         mask_q      <= '0;
         dec_code    <= '0;
         out_data    <= '0;
         out_match   <= 1'b0;
         out_timeout <= 1'b0;
         timer       <= '0;
      end else begin
         if (accept) begin
            enc_data    <= in_data;
            mask_q      <= in_mask;
            out_data    <= '0;
            out_match   <= 1'b0;
            out_timeout <= 1'b0;
         end
         if (timer_clear) begin
            timer <= '0;
         end else if (timer_inc) begin
            timer <= timer + TW'(1);
         end
         if (enc_capture) begin
            dec_code <= enc_code ^ mask_q;
         end
         if (dec_capture) begin
            out_data    <= dec_data;
            out_match   <= (dec_data == enc_data);
            out_timeout <= 1'b0;
         end
         if (abort) begin
            out_data    <= '0;
            out_match   <= 1'b0;
            out_timeout <= 1'b1;
         end
      end
   end

   // Saturating statistics, updated only on the edge where the result is handed off.
   always_ff @(posedge clk) begin
      if (!reset) begin
         word_cnt <= '0;
         fail_cnt <= '0;
      end else if (result_take) begin
         if (word_cnt != CNT_MAX) begin
            word_cnt <= word_cnt + CNT_W'(1);
         end
         if (!out_match && (fail_cnt != CNT_MAX)) begin
            fail_cnt <= fail_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_codec_sequencer.sv
// tb_codec_sequencer
// Directed and randomized words through codec_sequencer with toy encoder and
// decoder responders. Expected results come from a word-level model of the
// sequencer: codec arithmetic, handshake latencies, timeouts and saturating counts.

module tb_codec_sequencer;

   localparam int K       = 40;
   localparam int N       = 64;
   localparam int TIMEOUT = 8;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [K-1:0]     in_data;
   logic [N-1:0]     in_mask;
   logic             enc_start;
   logic [K-1:0]     enc_data;
   logic [N-1:0]     enc_code;
   logic             enc_done;
   logic             dec_start;
   logic [N-1:0]     dec_code;
   logic [K-1:0]     dec_data;
   logic             dec_done;
   logic             out_valid;
   logic             out_ready;
   logic [K-1:0]     out_data;
   logic             out_match;
   logic             out_timeout;
   logic [CNT_W-1:0] word_cnt;
   logic [CNT_W-1:0] fail_cnt;

   int vectors     = 0;
   int miscompares = 0;
   int exp_words   = 0;
   int exp_fails   = 0;
   int cyc         = 0;

   int enc_lat       = 3;
   int dec_lat       = 3;
   int enc_pulses    = 0;
   int dec_pulses    = 0;
   int enc_start_cyc = 0;
   logic [K-1:0] enc_seen;
   logic [N-1:0] dec_seen;

   codec_sequencer #(
      .K(K), .N(N), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mask(in_mask),
      .enc_start(enc_start), .enc_data(enc_data), .enc_code(enc_code), .enc_done(enc_done),
      .dec_start(dec_start), .dec_code(dec_code), .dec_data(dec_data), .dec_done(dec_done),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_match(out_match), .out_timeout(out_timeout),
      .word_cnt(word_cnt), .fail_cnt(fail_cnt)
   );

   // Free-running clock and cycle index (cycle numbers are read at the falling edge).
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Toy systematic code: 24 parity bits over the 40 data bits.
   function automatic logic [63:0] enc_fn(input logic [39:0] d);
      return {d[39:16] ^ d[23:0], d};
   endfunction

   // Toy decoder: a non-zero syndrome corrupts the low data bits.
   function automatic logic [39:0] dec_fn(input logic [63:0] c);
      logic [23:0] syn;
      syn = c[63:40] ^ c[39:16] ^ c[23:0];
      return c[39:0] ^ {16'h0, syn};
   endfunction

   // Encoder responder: done pulse for one cycle, enc_lat-1 falling edges after seeing start (0 = never).
   initial begin
      enc_done = 1'b0;
      enc_code = '0;
      forever begin
         @(negedge clk);
         if (enc_start) begin
            enc_pulses++;
            enc_seen      = enc_data;
            enc_start_cyc = cyc;
            if (enc_lat > 0) begin
               repeat (enc_lat - 1) @(negedge clk);
               enc_code = enc_fn(enc_seen);
               enc_done = 1'b1;
               @(negedge clk);
               enc_done = 1'b0;
            end
         end
      end
   end

   // Decoder responder, same timing rules as the encoder responder.
   initial begin
      dec_done = 1'b0;
      dec_data = '0;
      forever begin
         @(negedge clk);
         if (dec_start) begin
            dec_pulses++;
            dec_seen = dec_code;
            if (dec_lat > 0) begin
               repeat (dec_lat - 1) @(negedge clk);
               dec_data = dec_fn(dec_seen);
               dec_done = 1'b1;
               @(negedge clk);
               dec_done = 1'b0;
            end
         end
      end
   end

   // Global time limit so a stuck design still ends the run.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: observed still running, expected finish");
      $fatal(1, "[TB] time limit reached");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic holdReset(input int cycles);
      @(negedge clk);
      reset    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (cycles) @(negedge clk);
      exp_words = 0;
      exp_fails = 0;
   endtask

   // One complete word: offer it, wait for the result, optionally stall, then hand it off.
   task automatic applyStimulus(input logic [K-1:0] data, input logic [N-1:0] mask,
                                input int elat, input int dlat, input int stall);
      int ep, dp, lat_exp, waited;
      logic enc_ok, dec_ok, exp_match, exp_to;
      logic [K-1:0] exp_out;
      logic [N-1:0] code;

      enc_lat = elat;
      dec_lat = dlat;
      ep      = enc_pulses;
      dp      = dec_pulses;

      // A done pulse only counts if it lands inside the wait window of TIMEOUT cycles.
      enc_ok = (elat >= 2) && (elat <= TIMEOUT + 1);
      dec_ok = (dlat >= 2) && (dlat <= TIMEOUT + 1);
      code   = enc_fn(data) ^ mask;
      if (!enc_ok) begin
         lat_exp = TIMEOUT + 1;
         exp_out = '0; exp_match = 1'b0; exp_to = 1'b1;
      end else if (!dec_ok) begin
         lat_exp = elat + TIMEOUT + 1;
         exp_out = '0; exp_match = 1'b0; exp_to = 1'b1;
      end else begin
         lat_exp   = elat + dlat;
         exp_out   = dec_fn(code);
         exp_match = (exp_out == data);
         exp_to    = 1'b0;
      end

      @(negedge clk);
      checkOutput("in_ready_idle", 64'(in_ready), 64'(1));
      in_valid = 1'b1;
      in_data  = data;
      in_mask  = mask;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = {8'($urandom), 32'($urandom)};
      in_mask  = {32'($urandom), 32'($urandom)};

      waited = 0;
      while (!out_valid && waited < 60) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("out_valid_seen", 64'(out_valid), 64'(1));
      checkOutput("latency", 64'(cyc - enc_start_cyc), 64'(lat_exp));
      checkOutput("enc_start_pulses", 64'(enc_pulses - ep), 64'(1));
      checkOutput("dec_start_pulses", 64'(dec_pulses - dp), 64'(enc_ok));
      checkOutput("enc_data", 64'(enc_seen), 64'(data));
      if (enc_ok) checkOutput("dec_code", dec_seen, code);
      checkOutput("out_data", 64'(out_data), 64'(exp_out));
      checkOutput("out_match", 64'(out_match), 64'(exp_match));
      checkOutput("out_timeout", 64'(out_timeout), 64'(exp_to));
      checkOutput("in_ready_busy", 64'(in_ready), 64'(0));
      checkOutput("word_cnt_before", 64'(word_cnt), 64'(exp_words));

      for (int i = 0; i < stall; i++) begin
         in_valid = (i % 2 == 0);
         in_data  = {8'($urandom), 32'($urandom)};
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (stall > 0) begin
         checkOutput("stall_out_valid", 64'(out_valid), 64'(1));
         checkOutput("stall_out_data", 64'(out_data), 64'(exp_out));
         checkOutput("stall_out_timeout", 64'(out_timeout), 64'(exp_to));
         checkOutput("stall_in_ready", 64'(in_ready), 64'(0));
         checkOutput("stall_enc_data", 64'(enc_data), 64'(data));
         checkOutput("stall_enc_pulses", 64'(enc_pulses - ep), 64'(1));
         checkOutput("stall_word_cnt", 64'(word_cnt), 64'(exp_words));
         checkOutput("stall_fail_cnt", 64'(fail_cnt), 64'(exp_fails));
      end

      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      if (exp_words < CNT_MAX) exp_words++;
      if (!exp_match && exp_fails < CNT_MAX) exp_fails++;
      checkOutput("word_cnt", 64'(word_cnt), 64'(exp_words));
      checkOutput("fail_cnt", 64'(fail_cnt), 64'(exp_fails));
      checkOutput("out_valid_after", 64'(out_valid), 64'(0));
      checkOutput("in_ready_after", 64'(in_ready), 64'(1));
   endtask

   // Directed scenarios first, then randomized words with periodic resets.
   initial begin
      int waited, dp;
      logic [K-1:0] data;
      logic [N-1:0] mask;
      int elat, dlat;

      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_mask   = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_in_ready", 64'(in_ready), 64'(1));
      checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
      checkOutput("reset_enc_start", 64'(enc_start), 64'(0));
      reset = 1'b1;

      $display("[TB] nominal and corrupted words");
      applyStimulus(40'h9D_5486_AA91, 64'h0, 3, 3, 0);
      applyStimulus(40'h9D_5486_AA91, 64'hD900_0000_0000_0000, 3, 3, 0);

      $display("[TB] reset in the middle of the decoder wait");
      enc_lat = 2;
      dec_lat = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 40'h12_3456_789A;
      in_mask  = '0;
      @(negedge clk);
      in_valid = 1'b0;
      dp = dec_pulses;
      waited = 0;
      while (dec_pulses == dp && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("rst_reached_dec_wait", 64'(dec_pulses - dp), 64'(1));
      @(negedge clk);
      holdReset(3);
      checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
      checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
      checkOutput("rst_word_cnt", 64'(word_cnt), 64'(0));
      checkOutput("rst_fail_cnt", 64'(fail_cnt), 64'(0));
      checkOutput("rst_out_data", 64'(out_data), 64'(0));
      checkOutput("rst_enc_data", 64'(enc_data), 64'(0));
      checkOutput("rst_dec_code", dec_code, 64'(0));
      reset = 1'b1;

      $display("[TB] reset during encoder wait, late done ignored");
      enc_lat = 6;
      dec_lat = 3;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 40'hAB_CDEF_0123;
      @(negedge clk);
      in_valid = 1'b0;
      holdReset(2);
      reset = 1'b1;
      dp = dec_pulses;
      repeat (10) @(negedge clk);
      checkOutput("late_done_dec_start", 64'(dec_pulses - dp), 64'(0));
      checkOutput("late_done_out_valid", 64'(out_valid), 64'(0));
      checkOutput("late_done_in_ready", 64'(in_ready), 64'(1));

      $display("[TB] timeouts");
      applyStimulus(40'h55_AA55_AA55, 64'h0, 0, 3, 0);
      applyStimulus(40'h01_0203_0405, 64'h0, 1, 3, 0);
      applyStimulus(40'hFE_DCBA_9876, 64'h0, 3, 0, 0);

      $display("[TB] backpressure");
      holdReset(2);
      reset = 1'b1;
      applyStimulus(40'h9D_5486_AA91, 64'h0, 4, 2, 10);
      applyStimulus(40'h31_4159_2653, 64'hD900_0000_0000_0000, 2, 9, 10);

      $display("[TB] counter saturation");
      holdReset(2);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         applyStimulus({8'(i), 32'($urandom)}, 64'hD900_0000_0000_0000, 3, 3, 0);
      end
      checkOutput("sat_word_cnt", 64'(word_cnt), 64'(3));
      checkOutput("sat_fail_cnt", 64'(fail_cnt), 64'(3));

      $display("[TB] randomized words");
      for (int w = 0; w < 15; w++) begin
         if (w % 3 == 0) begin
            holdReset(2);
            reset = 1'b1;
         end
         data = {8'($urandom), 32'($urandom)};
         case ($urandom_range(0, 2))
            0:       mask = '0;
            1:       mask = {32'($urandom), 32'($urandom)};
            default: mask = 64'(1) << $urandom_range(0, 63);
         endcase
         elat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 9));
         dlat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 9));
         applyStimulus(data, mask, elat, dlat, int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
